// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
// State enum, opcodes, datapath select codes and the control output bundle.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BEQ_EX   = 4'd8,
    ADDI_EX  = 4'd9,
    ADDI_WB  = 4'd10,
    J_EX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_out_t;

  function automatic logic is_known_op(
    input logic [5:0] op
  );
    return (op == OP_R)   || (op == OP_LW)
        || (op == OP_SW)  || (op == OP_BEQ)
        || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control <-> datapath bundle for the multicycle MIPS controller.
// master = controller side, slave = datapath side.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, iord,
    output mem_read, mem_write, ir_write,
    output mem_to_reg, reg_dst, reg_write,
    output alu_src_a, alu_src_b, alu_op,
    output pc_source, instr_done, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, iord,
    input  mem_read, mem_write, ir_write,
    input  mem_to_reg, reg_dst, reg_write,
    input  alu_src_a, alu_src_b, alu_op,
    input  pc_source, instr_done, illegal_op
  );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Moore output decode of the control state, with the memory-gated
// enables (ir_write, pc_write, instr_done) qualified by mem_ready.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t    state,
  input  logic      mem_ready,
  output ctrl_out_t ctrl
);

  // Per-state datapath controls; anything not set stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM2;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALU_FUNCT;
      end
      RTYPE_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BEQ_EX: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_OUT;
        ctrl.instr_done    = 1'b1;
      end
      ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      J_EX: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath.
// Sequences FETCH/DECODE/execute states, stalls on mem_ready, flags bad opcodes.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  mips_multicycle_control_if.master bus
);

  state_t    state_q;
  state_t    state_d;
  logic      ill_q;
  logic      mr;
  logic      known;
  logic      bad_dec;
  ctrl_out_t dec;

  assign mr      = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
  assign known   = is_known_op(bus.opcode);
  assign bad_dec = (state_q == DECODE) && !known;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Sticky illegal-opcode flag, set when DECODE sees an unknown opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ill_q <= 1'b0;
    else if (bad_dec) ill_q <= 1'b1;
  end

  // Next-state; unused encodings fall back to FETCH
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mr ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW,
          OP_SW:   state_d = MEMADR;
          OP_R:    state_d = RTYPE_EX;
          OP_BEQ:  state_d = BEQ_EX;
          OP_ADDI: state_d = ADDI_EX;
          OP_J:    state_d = J_EX;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (bus.opcode == OP_LW)
                        ? MEMRD : MEMWR;
      MEMRD:    state_d = mr ? MEMWB : MEMRD;
      MEMWB:    state_d = FETCH;
      MEMWR:    state_d = mr ? FETCH : MEMWR;
      RTYPE_EX: state_d = RTYPE_WB;
      RTYPE_WB: state_d = FETCH;
      BEQ_EX:   state_d = FETCH;
      ADDI_EX:  state_d = ADDI_WB;
      ADDI_WB:  state_d = FETCH;
      J_EX:     state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mr),
    .ctrl      (dec)
  );

  // Drive the bus; everything held at 0 while reset is asserted
  always_comb begin
    bus.pc_write      = rst_n & dec.pc_write;
    bus.pc_write_cond = rst_n & dec.pc_write_cond;
    bus.iord          = rst_n & dec.iord;
    bus.mem_read      = rst_n & dec.mem_read;
    bus.mem_write     = rst_n & dec.mem_write;
    bus.ir_write      = rst_n & dec.ir_write;
    bus.mem_to_reg    = rst_n & dec.mem_to_reg;
    bus.reg_dst       = rst_n & dec.reg_dst;
    bus.reg_write     = rst_n & dec.reg_write;
    bus.alu_src_a     = rst_n & dec.alu_src_a;
    bus.alu_src_b     = rst_n ? dec.alu_src_b : 2'b00;
    bus.alu_op        = rst_n ? dec.alu_op : 2'b00;
    bus.pc_source     = rst_n ? dec.pc_source : 2'b00;
    bus.instr_done    = rst_n & (dec.instr_done | bad_dec);
    bus.illegal_op    = rst_n & ill_q;
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized scoreboard bench for mips_multicycle_control.
// Driver expands each instruction into per-cycle expectations; monitor compares.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } obs_t;

  typedef struct {
    obs_t  exp;
    string tag;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   ill_m = 1'b0;
  bit   done = 1'b0;
  sb_t  sbq[$];

  mips_multicycle_control_if bus ();

  mips_multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  obs_t got;
  assign got = '{
    bus.pc_write, bus.pc_write_cond, bus.iord,
    bus.mem_read, bus.mem_write, bus.ir_write,
    bus.mem_to_reg, bus.reg_dst, bus.reg_write,
    bus.alu_src_a, bus.alu_src_b, bus.alu_op,
    bus.pc_source, bus.instr_done, bus.illegal_op};

  function automatic obs_t base();
    obs_t e;
    e = '0;
    e.illegal_op = ill_m;
    return e;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011
        || op == 6'b101011 || op == 6'b000100
        || op == 6'b001000 || op == 6'b000010;
  endfunction

  task automatic cyc(input logic r, input logic [5:0] op,
                     input logic mr, input obs_t e,
                     input string tag);
    sb_t s;
    @(posedge clk);
    #1;
    rst_n         = r;
    bus.opcode    = op;
    bus.mem_ready = mr;
    bus.zero      = 1'($urandom);
    s.exp = e;
    s.tag = tag;
    sbq.push_back(s);
  endtask

  task automatic do_fetch(input int w);
    obs_t e;
    for (int i = 0; i <= w; i++) begin
      e = base();
      e.mem_read  = 1'b1;
      e.alu_src_b = 2'b01;
      if (i == w) begin
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
      end
      cyc(1'b1, 6'($urandom), logic'(i == w), e, "fetch");
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf,
                           input int wm);
    obs_t e;
    do_fetch(wf);
    e = base();
    e.alu_src_b = 2'b11;
    if (!legal(op)) e.instr_done = 1'b1;
    cyc(1'b1, op, 1'($urandom), e, "decode");
    if (!legal(op)) begin
      ill_m = 1'b1;
      return;
    end
    case (op)
      6'b100011, 6'b101011: begin
        e = base();
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        cyc(1'b1, op, 1'($urandom), e, "memadr");
        for (int i = 0; i <= wm; i++) begin
          e = base();
          e.iord = 1'b1;
          if (op == 6'b100011) e.mem_read = 1'b1;
          else begin
            e.mem_write  = 1'b1;
            e.instr_done = logic'(i == wm);
          end
          cyc(1'b1, op, logic'(i == wm), e, "memacc");
        end
        if (op == 6'b100011) begin
          e = base();
          e.reg_write  = 1'b1;
          e.mem_to_reg = 1'b1;
          e.instr_done = 1'b1;
          cyc(1'b1, op, 1'($urandom), e, "memwb");
        end
      end
      6'b000000: begin
        e = base();
        e.alu_src_a = 1'b1;
        e.alu_op    = 2'b10;
        cyc(1'b1, op, 1'($urandom), e, "rtype_ex");
        e = base();
        e.reg_write  = 1'b1;
        e.reg_dst    = 1'b1;
        e.instr_done = 1'b1;
        cyc(1'b1, op, 1'($urandom), e, "rtype_wb");
      end
      6'b000100: begin
        e = base();
        e.alu_src_a     = 1'b1;
        e.alu_op        = 2'b01;
        e.pc_write_cond = 1'b1;
        e.pc_source     = 2'b01;
        e.instr_done    = 1'b1;
        cyc(1'b1, op, 1'($urandom), e, "beq_ex");
      end
      6'b001000: begin
        e = base();
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        cyc(1'b1, op, 1'($urandom), e, "addi_ex");
        e = base();
        e.reg_write  = 1'b1;
        e.instr_done = 1'b1;
        cyc(1'b1, op, 1'($urandom), e, "addi_wb");
      end
      default: begin
        e = base();
        e.pc_write   = 1'b1;
        e.pc_source  = 2'b10;
        e.instr_done = 1'b1;
        cyc(1'b1, op, 1'($urandom), e, "j_ex");
      end
    endcase
  endtask

  task automatic reset_in_memrd();
    obs_t e;
    do_fetch(0);
    e = base();
    e.alu_src_b = 2'b11;
    cyc(1'b1, 6'b100011, 1'b1, e, "rdecode");
    e = base();
    e.alu_src_a = 1'b1;
    e.alu_src_b = 2'b10;
    cyc(1'b1, 6'b100011, 1'b1, e, "rmemadr");
    e = base();
    e.mem_read = 1'b1;
    e.iord     = 1'b1;
    cyc(1'b1, 6'b100011, 1'b0, e, "rmemrd");
    ill_m = 1'b0;
    cyc(1'b0, 6'b100011, 1'b1, '0, "in_reset");
    cyc(1'b0, 6'b100011, 1'b1, '0, "in_reset");
  endtask

  // Monitor: compare the DUT against the oldest pending expectation
  always @(negedge clk) begin
    sb_t s;
    if (sbq.size() > 0) begin
      s = sbq.pop_front();
      checks++;
      if (got !== s.exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", s.tag, got, s.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    if (!done) begin
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
    end
  end

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    int k;
    ops = '{6'b000000, 6'b100011, 6'b101011,
            6'b000100, 6'b001000, 6'b000010};
    bus.opcode    = 6'b0;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    cyc(1'b0, 6'b100011, 1'b1, '0, "reset");
    cyc(1'b0, 6'b100011, 1'b1, '0, "reset");
    run_instr(6'b100011, 0, 0);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b001000, 3, 0);
    run_instr(6'b101011, 0, 2);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b001000, 0, 0);
    reset_in_memrd();
    run_instr(6'b100011, 1, 1);
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 6);
      if (k == 6) op = 6'($urandom);
      else        op = ops[k];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      if (n == 100) reset_in_memrd();
    end
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", sbq.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
